param_databuffer: RTL and testbench

PARAM_DATABUFFER -- requirements
Module: param_databuffer

---
 rtl/param_databuffer_if.sv | 39 +++
 rtl/param_databuffer.sv | 120 ++++++++++++
 tb/tb_param_databuffer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/param_databuffer_if.sv
// Bus bundle for param_databuffer: AHB-side word access, USB-side byte access and status.
// The slave modport is the buffer itself; the master modport is whoever drives it.
interface param_databuffer_if #(
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned AHB_BYTES = 4
);
    localparam int unsigned OW = $clog2(DEPTH) + 1;
    localparam int unsigned DW = 8 * AHB_BYTES;

    logic          clear;
    logic          flush;
    logic          store_tx_data;
    logic [1:0]    tx_size;
    logic [DW-1:0] tx_data;
    logic          get_rx_data;
    logic [1:0]    rx_size;
    logic [DW-1:0] rx_data;
    logic          store_rx_packet_data;
    logic [7:0]    rx_packet_data;
    logic          get_tx_packet_data;
    logic [7:0]    tx_packet_data;
    logic [OW-1:0] buffer_occupancy;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          underflow;

    modport master (
        output clear, flush, store_tx_data, tx_size, tx_data, get_rx_data, rx_size,
               store_rx_packet_data, rx_packet_data, get_tx_packet_data,
        input  rx_data, tx_packet_data, buffer_occupancy, full, empty, overflow, underflow
    );

    modport slave (
        input  clear, flush, store_tx_data, tx_size, tx_data, get_rx_data, rx_size,
               store_rx_packet_data, rx_packet_data, get_tx_packet_data,
        output rx_data, tx_packet_data, buffer_occupancy, full, empty, overflow, underflow
    );
endinterface

// File: rtl/param_databuffer.sv
// Circular byte FIFO shared by an AHB word port and a USB byte port.
// Define DATABUF_ERR_DETECT_EN to get sticky overflow/underflow flags; otherwise they are 0.
module param_databuffer #(
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned AHB_BYTES = 4
) (
    input logic               clk,
    input logic               rst,
    param_databuffer_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned OW = AW + 1;
    localparam int unsigned DW = 8 * AHB_BYTES;

    // Size codes above the bus width collapse to the bus width.
    function automatic logic [OW-1:0] size_bytes(input logic [1:0] code);
        logic [OW-1:0] n;
        n = OW'(1) << code;
        if (n > OW'(AHB_BYTES)) n = OW'(AHB_BYTES);
        return n;
    endfunction

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [OW-1:0] occ_q, occ_d;
    logic [DW-1:0] rx_data_q, rd_word;
    logic [7:0]    tx_byte_q;

    logic [OW-1:0] tx_n, rx_n, wr_n, rd_n;
    logic          full, empty, sync_clr;
    logic          ahb_wr_ok, usb_wr_ok, ahb_rd_ok, usb_rd_ok;

    always_comb begin
        tx_n      = size_bytes(bus.tx_size);
        rx_n      = size_bytes(bus.rx_size);
        full      = (occ_q == OW'(DEPTH));
        empty     = (occ_q == '0);
        sync_clr  = bus.clear || bus.flush;
        // Extra bit so occupancy + n cannot wrap before the capacity compare.
        ahb_wr_ok = bus.store_tx_data &&
                    (({1'b0, occ_q} + {1'b0, tx_n}) <= (OW + 1)'(DEPTH));
        usb_wr_ok = bus.store_rx_packet_data && !bus.store_tx_data && !full;
        ahb_rd_ok = bus.get_rx_data && (occ_q >= rx_n);
        usb_rd_ok = bus.get_tx_packet_data && !bus.get_rx_data && !empty;
        wr_n      = ahb_wr_ok ? tx_n : (usb_wr_ok ? OW'(1) : '0);
        rd_n      = ahb_rd_ok ? rx_n : (usb_rd_ok ? OW'(1) : '0);
        occ_d     = occ_q + wr_n - rd_n;
        rd_word   = '0;
        for (int unsigned k = 0; k < AHB_BYTES; k++) begin
            if (OW'(k) < rx_n) rd_word[8*k +: 8] = mem_q[rptr_q + AW'(k)];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            occ_q     <= '0;
            rx_data_q <= '0;
            tx_byte_q <= '0;
        end else if (sync_clr) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            occ_q     <= '0;
            rx_data_q <= '0;
            tx_byte_q <= '0;
        end else begin
            wptr_q <= wptr_q + AW'(wr_n);
            rptr_q <= rptr_q + AW'(rd_n);
            occ_q  <= occ_d;
            if (ahb_rd_ok) rx_data_q <= rd_word;
            if (usb_rd_ok) tx_byte_q <= mem_q[rptr_q];
        end
    end

    // Storage needs no reset: pointers and occupancy define what is valid.
    always_ff @(posedge clk) begin
        if (!sync_clr) begin
            for (int unsigned k = 0; k < AHB_BYTES; k++) begin
                if (ahb_wr_ok && (OW'(k) < tx_n)) mem_q[wptr_q + AW'(k)] <= bus.tx_data[8*k +: 8];
            end
            if (usb_wr_ok) mem_q[wptr_q] <= bus.rx_packet_data;
        end
    end

`ifdef DATABUF_ERR_DETECT_EN
    logic overflow_q, underflow_q;
    logic wr_drop, rd_drop;

    always_comb begin
        wr_drop = (bus.store_tx_data && !ahb_wr_ok) || (bus.store_rx_packet_data && !usb_wr_ok);
        rd_drop = (bus.get_rx_data && !ahb_rd_ok) || (bus.get_tx_packet_data && !usb_rd_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (sync_clr) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_drop) overflow_q <= 1'b1;
            if (rd_drop) underflow_q <= 1'b1;
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif

    assign bus.rx_data          = rx_data_q;
    assign bus.tx_packet_data   = tx_byte_q;
    assign bus.buffer_occupancy = occ_q;
    assign bus.full             = full;
    assign bus.empty            = empty;
endmodule

// File: tb/tb_param_databuffer.sv
// Directed bench for param_databuffer (DEPTH 64, AHB_BYTES 4) with a byte-queue model
// and a queue of expected read results.
module tb_param_databuffer;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned AHB_BYTES = 4;
`ifdef DATABUF_ERR_DETECT_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    logic tb_clk = 1'b0;
    logic rst = 1'b1;
    always #5 tb_clk = ~tb_clk;

    param_databuffer_if #(.DEPTH(DEPTH), .AHB_BYTES(AHB_BYTES)) bus ();

    param_databuffer #(.DEPTH(DEPTH), .AHB_BYTES(AHB_BYTES)) dut (
        .clk (tb_clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0]  model[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_rx;
    logic [7:0]  exp_tx;
    logic        exp_ovf, exp_unf;
    int          checks = 0;
    int          errors = 0;

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, ".occ"}, 32'(bus.buffer_occupancy), 32'(model.size()));
        check({tag, ".full"}, 32'(bus.full), 32'(model.size() == DEPTH));
        check({tag, ".empty"}, 32'(bus.empty), 32'(model.size() == 0));
        check({tag, ".ovf"}, 32'(bus.overflow), 32'(exp_ovf));
        check({tag, ".unf"}, 32'(bus.underflow), 32'(exp_unf));
    endtask

    function automatic int nbytes(input logic [1:0] code);
        int n;
        n = 1 << code;
        return (n > AHB_BYTES) ? AHB_BYTES : n;
    endfunction

    task automatic ahb_write(input logic [1:0] size, input logic [31:0] data);
        int n;
        n = nbytes(size);
        bus.store_tx_data = 1'b1;
        bus.tx_size = size;
        bus.tx_data = data;
        if (model.size() + n <= DEPTH) begin
            for (int k = 0; k < n; k++) model.push_back(data[8*k +: 8]);
        end else if (ErrEn) begin
            exp_ovf = 1'b1;
        end
        tick();
        bus.store_tx_data = 1'b0;
    endtask

    task automatic usb_write(input logic [7:0] b);
        bus.store_rx_packet_data = 1'b1;
        bus.rx_packet_data = b;
        if (model.size() < DEPTH) model.push_back(b);
        else if (ErrEn) exp_ovf = 1'b1;
        tick();
        bus.store_rx_packet_data = 1'b0;
    endtask

    task automatic usb_read(input string tag);
        if (model.size() > 0) exp_tx = model.pop_front();
        else if (ErrEn) exp_unf = 1'b1;
        exp_q.push_back(32'(exp_tx));
        bus.get_tx_packet_data = 1'b1;
        tick();
        bus.get_tx_packet_data = 1'b0;
        check(tag, 32'(bus.tx_packet_data), exp_q.pop_front());
    endtask

    task automatic ahb_read(input string tag, input logic [1:0] size);
        int n;
        logic [31:0] v;
        n = nbytes(size);
        if (model.size() >= n) begin
            v = '0;
            for (int k = 0; k < n; k++) v[8*k +: 8] = model.pop_front();
            exp_rx = v;
        end else if (ErrEn) begin
            exp_unf = 1'b1;
        end
        exp_q.push_back(exp_rx);
        bus.get_rx_data = 1'b1;
        bus.rx_size = size;
        tick();
        bus.get_rx_data = 1'b0;
        check(tag, bus.rx_data, exp_q.pop_front());
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        model.delete();
        exp_rx = '0;
        exp_tx = '0;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        check("clr.rx", bus.rx_data, 32'h0);
        check("clr.tx", 32'(bus.tx_packet_data), 32'h0);
        check_status("clr");
    endtask

    initial begin
        bus.clear = 1'b0;
        bus.flush = 1'b0;
        bus.store_tx_data = 1'b0;
        bus.tx_size = 2'd0;
        bus.tx_data = '0;
        bus.get_rx_data = 1'b0;
        bus.rx_size = 2'd0;
        bus.store_rx_packet_data = 1'b0;
        bus.rx_packet_data = '0;
        bus.get_tx_packet_data = 1'b0;
        exp_rx = '0;
        exp_tx = '0;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;

        tick();
        tick();
        check("rst.rx", bus.rx_data, 32'h0);
        check("rst.tx", 32'(bus.tx_packet_data), 32'h0);
        check_status("rst");
        rst = 1'b0;
        tick();

        // Word write drained one byte at a time.
        ahb_write(2'd2, 32'hDDCCBBAA);
        check_status("w4");
        for (int i = 0; i < 4; i++) begin
            usb_read("usb_rd_word");
            check_status("usb_rd_word");
        end

        // Byte writes read back as a half-word, then an oversized read is refused.
        usb_write(8'h11);
        usb_write(8'h22);
        usb_write(8'h33);
        usb_write(8'h44);
        ahb_read("ahb_rd_half", 2'd1);
        check_status("ahb_rd_half");
        ahb_read("ahb_rd_rej", 2'd2);
        check_status("ahb_rd_rej");
        do_clear();

        // Offset the pointers by one so the fill below wraps.
        usb_write(8'hE1);
        usb_read("offset_rd");
        for (int i = 0; i < 16; i++) begin
            ahb_write(2'd2, {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
        end
        check_status("fill");
        ahb_write(2'd0, 32'h000000FF);
        check_status("fill_ovf_ahb");
        usb_write(8'hFE);
        check_status("fill_ovf_usb");
        for (int i = 0; i < 64; i++) usb_read("drain");
        check_status("drained");
        usb_read("rd_empty");
        check_status("rd_empty");
        do_clear();

        // Concurrent write and USB read at occupancy 1.
        usb_write(8'h5A);
        bus.store_tx_data = 1'b1;
        bus.tx_size = 2'd0;
        bus.tx_data = 32'h00000077;
        bus.get_tx_packet_data = 1'b1;
        exp_q.push_back(32'(model.pop_front()));
        exp_tx = 8'h5A;
        model.push_back(8'h77);
        tick();
        bus.store_tx_data = 1'b0;
        bus.get_tx_packet_data = 1'b0;
        check("rw_same", 32'(bus.tx_packet_data), exp_q.pop_front());
        check_status("rw_same");

        // Both write strobes: the AHB write wins.
        bus.store_tx_data = 1'b1;
        bus.tx_size = 2'd1;
        bus.tx_data = 32'h0000BEEF;
        bus.store_rx_packet_data = 1'b1;
        bus.rx_packet_data = 8'h99;
        model.push_back(8'hEF);
        model.push_back(8'hBE);
        if (ErrEn) exp_ovf = 1'b1;
        tick();
        bus.store_tx_data = 1'b0;
        bus.store_rx_packet_data = 1'b0;
        check_status("ww");

        // Both read strobes: the AHB read wins, USB output holds.
        bus.get_tx_packet_data = 1'b1;
        if (ErrEn) exp_unf = 1'b1;
        ahb_read("rr_ahb", 2'd0);
        bus.get_tx_packet_data = 1'b0;
        check("rr_tx_hold", 32'(bus.tx_packet_data), 32'(exp_tx));
        check_status("rr");

        // Flush wins over a concurrent store.
        bus.flush = 1'b1;
        bus.store_tx_data = 1'b1;
        bus.tx_size = 2'd2;
        bus.tx_data = 32'h12345678;
        tick();
        bus.flush = 1'b0;
        bus.store_tx_data = 1'b0;
        model.delete();
        exp_rx = '0;
        exp_tx = '0;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        check("flush.rx", bus.rx_data, 32'h0);
        check("flush.tx", 32'(bus.tx_packet_data), 32'h0);
        check_status("flush");

        // Size code 3 behaves as a full word; then reset mid-stream.
        ahb_write(2'd3, 32'h0D0C0B0A);
        usb_write(8'h3C);
        usb_read("sz3_usb");
        ahb_read("sz3_ahb", 2'd0);
        check_status("pre_rst");
        #2;
        rst = 1'b1;
        #1;
        model.delete();
        exp_rx = '0;
        exp_tx = '0;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        check("arst.rx", bus.rx_data, 32'h0);
        check("arst.tx", 32'(bus.tx_packet_data), 32'h0);
        check_status("arst");
        rst = 1'b0;
        tick();
        ahb_write(2'd1, 32'h0000A55A);
        ahb_read("post_rst", 2'd2);
        check_status("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
